a2d_arbiter: RTL
================

// Module: a2d_arbiter
// PURPOSE
//  Round-robin scheduler that shares the single SPI A2D converter among three requesters:
//  req0 = IR line-sensor sweep, req1 = battery monitor, req2 = diagnostic/host reads.
//  Sequences each conversion: grant, start, wait for complete, return result, then a recovery gap.
//  Sits between the sensing blocks (line_present / err generation) and the A2D SPI interface.
//  Guarantees no requester starves and no requester hangs on a dead converter (timeout).
// PARAMETERS
//  GAP_CYC  4   idle cycles after each conversion before the next grant (SS_n recovery)
//  TMO_W    16  timeout width; a conversion aborts after 2**TMO_W cycles in WAIT
// PORTS
//  clk        in   1   system clock
//  rst_n      in   1   asynchronous, active-low reset
//  req        in   3   per-requester conversion request, level; held until own gnt
//  req_chnl   in   9   channel per requester, {r2[2:0], r1[2:0], r0[2:0]}
//  gnt        out  3   one-hot, 1-cycle pulse: request accepted
//  done       out  3   one-hot, 1-cycle pulse: res_out valid for that requester
//  res_out    out  12  conversion result, held until next done
//  strt_cnv   out  1   1-cycle pulse to A2D interface
//  chnnl      out  3   channel to A2D interface, stable from strt_cnv until cnv_cmplt
//  cnv_cmplt  in   1   A2D interface conversion complete (1-cycle pulse)
//  a2d_res    in   12  A2D interface result, valid with cnv_cmplt
//  busy       out  1   high in every state except IDLE
//  tmo_err    out  1   sticky timeout flag
//  clr_err    in   1   synchronous clear of tmo_err
// BEHAVIOUR
//  Reset: state IDLE; gnt, done, strt_cnv, busy, tmo_err = 0; res_out = 0; chnnl = 0;
//   rr pointer = 2, so requester 0 has highest priority after reset. Reset mid-conversion
//   abandons it; the result of a late cnv_cmplt is discarded.
//  All outputs are registered.
//  FSM IDLE -> ISSUE -> WAIT -> DONE -> GAP -> IDLE.
//  IDLE: sample req; if any set, winner = first set bit searching ptr+1, ptr+2, ptr (mod 3);
//   latch winner index and its req_chnl slice; go to ISSUE.
//  ISSUE (1 cycle): gnt[w]=1, strt_cnv=1, chnnl=latched channel; clear timer; go to WAIT.
//  WAIT: chnnl held; timer increments. On cnv_cmplt: res_out <= a2d_res; go to DONE.
//   If the timer reaches 2**TMO_W-1 without cnv_cmplt: res_out <= 12'h000, tmo_err <= 1;
//   go to DONE. Requester therefore always receives done.
//  DONE (1 cycle): done[w]=1; ptr <= w; clear timer; go to GAP.
//  GAP: count GAP_CYC cycles, then IDLE. GAP_CYC = 0 means GAP lasts 1 cycle.
//  Latency: req high in IDLE at cycle N -> gnt/strt_cnv at N+1.
//   cnv_cmplt at cycle M -> done and res_out valid at M+1.
//   Next gnt no earlier than M+3+GAP_CYC.
//  Requests that are pending but not granted are not latched. Dropping req before gnt
//   withdraws it. req_chnl is sampled only in the IDLE cycle that grants.
//  cnv_cmplt outside WAIT is ignored. cnv_cmplt in the same cycle as the timeout wins:
//   the real result is stored and tmo_err is not set.
//  clr_err and a new timeout in the same cycle: the set wins.
//  A requester may reassert req in its done cycle. Rotation makes it lowest priority next round.
//  Fairness: with all three requesting continuously, grants follow 0,1,2,0,1,2...
// TESTING
//  T1 Reset, then req=3'b001 with r0 chnl=3. Expect gnt=001 and strt_cnv one cycle later,
//     chnnl=3. Drive cnv_cmplt, a2d_res=12'hA5C 10 cycles later. Expect done=001 and
//     res_out=12'hA5C on the next cycle.
//  T2 Hold req=3'b111 for 6 conversions. Expect grant order 0,1,2,0,1,2. Expect exactly
//     GAP_CYC+3 cycles minimum from each cnv_cmplt to the next strt_cnv.
//  T3 Never assert cnv_cmplt. Expect done pulse at timeout with res_out=0 and tmo_err=1.
//     Expect tmo_err to stay 1 until clr_err, then 0.
//  T4 Drive cnv_cmplt during IDLE and GAP. Expect no done, res_out unchanged, FSM unaffected.
//  T5 Assert rst_n low during WAIT. Expect all outputs 0 and ptr reset. Then drive a late
//     cnv_cmplt. Expect no done. Then req=3'b110. Expect requester 1 granted first.
//  T6 Drop req1 while requester 0's conversion is active, with req2 still high.
//     Expect next grant to requester 2.

Source files
------------

// File: rtl/a2d_arbiter_if.sv
// Bundle of the requester-side and converter-side signals of the A2D round-robin arbiter.
// The slave modport is the arbiter's view; master is the environment driving it.
interface a2d_arbiter_if;
    // Handshake: req is a level held until the matching one-hot gnt pulse; done marks
    // res_out valid for one cycle; strt_cnv/cnv_cmplt are single-cycle pulses to/from the A2D.
    logic [2:0]  req;
    logic [8:0]  req_chnl;
    logic [2:0]  gnt;
    logic [2:0]  done;
    logic [11:0] res_out;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        cnv_cmplt;
    logic [11:0] a2d_res;
    logic        busy;
    logic        tmo_err;
    logic        clr_err;
    logic [2:0]  dbg_state;

    modport slave (
        input  req, req_chnl, cnv_cmplt, a2d_res, clr_err,
        output gnt, done, res_out, strt_cnv, chnnl, busy, tmo_err, dbg_state
    );

    modport master (
        output req, req_chnl, cnv_cmplt, a2d_res, clr_err,
        input  gnt, done, res_out, strt_cnv, chnnl, busy, tmo_err, dbg_state
    );
endinterface

// File: rtl/a2d_arbiter.sv
// Round-robin scheduler sharing one SPI A2D converter among three requesters, with
// per-conversion timeout, recovery gap and a sticky timeout flag.
module a2d_arbiter #(
    parameter int GAP_CYC = 4,
    parameter int TMO_W   = 16
) (
    input logic           clk,
    input logic           rst_n,
    a2d_arbiter_if.slave  bus
);

    localparam int GAP_N = (GAP_CYC < 1) ? 1 : GAP_CYC;
    localparam int GAP_W = (GAP_N < 2) ? 1 : $clog2(GAP_N);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t           r_state;
    logic [1:0]       r_ptr;
    logic [1:0]       r_win;
    logic [TMO_W-1:0] r_tmr;
    logic [GAP_W-1:0] r_gap;
    logic [2:0]       r_gnt;
    logic [2:0]       r_done;
    logic [11:0]      r_res;
    logic             r_strt;
    logic [2:0]       r_chnnl;
    logic             r_busy;
    logic             r_tmo_err;

    logic [1:0]       w_win;
    logic             w_any;
    logic [2:0]       w_chnl;

    // Search starts just after the last served requester, so it becomes lowest priority.
    always_comb begin
        w_any = |bus.req;
        w_win = 2'd0;
        case (r_ptr)
            2'd0: begin
                if (bus.req[1])      w_win = 2'd1;
                else if (bus.req[2]) w_win = 2'd2;
                else                 w_win = 2'd0;
            end
            2'd1: begin
                if (bus.req[2])      w_win = 2'd2;
                else if (bus.req[0]) w_win = 2'd0;
                else                 w_win = 2'd1;
            end
            default: begin
                if (bus.req[0])      w_win = 2'd0;
                else if (bus.req[1]) w_win = 2'd1;
                else                 w_win = 2'd2;
            end
        endcase
    end

    always_comb begin
        w_chnl = bus.req_chnl[2:0];
        case (w_win)
            2'd1:    w_chnl = bus.req_chnl[5:3];
            2'd2:    w_chnl = bus.req_chnl[8:6];
            default: w_chnl = bus.req_chnl[2:0];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_ptr     <= 2'd2;
            r_win     <= 2'd0;
            r_tmr     <= '0;
            r_gap     <= '0;
            r_gnt     <= 3'b000;
            r_done    <= 3'b000;
            r_res     <= 12'h000;
            r_strt    <= 1'b0;
            r_chnnl   <= 3'd0;
            r_busy    <= 1'b0;
            r_tmo_err <= 1'b0;
        end else begin
            // Clear first so a timeout set later in this cycle takes precedence.
            if (bus.clr_err) r_tmo_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_win   <= w_win;
                        r_gnt   <= 3'b001 << w_win;
                        r_strt  <= 1'b1;
                        r_chnnl <= w_chnl;
                        r_busy  <= 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_gnt   <= 3'b000;
                    r_strt  <= 1'b0;
                    r_tmr   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.cnv_cmplt) begin
                        r_res   <= bus.a2d_res;
                        r_done  <= 3'b001 << r_win;
                        r_state <= S_DONE;
                    end else if (&r_tmr) begin
                        r_res     <= 12'h000;
                        r_tmo_err <= 1'b1;
                        r_done    <= 3'b001 << r_win;
                        r_state   <= S_DONE;
                    end else begin
                        r_tmr <= r_tmr + 1'b1;
                    end
                end
                S_DONE: begin
                    r_done  <= 3'b000;
                    r_ptr   <= r_win;
                    r_tmr   <= '0;
                    r_gap   <= '0;
                    r_state <= S_GAP;
                end
                S_GAP: begin
                    if (r_gap == GAP_W'(GAP_N - 1)) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.done      = r_done;
    assign bus.res_out   = r_res;
    assign bus.strt_cnv  = r_strt;
    assign bus.chnnl     = r_chnnl;
    assign bus.busy      = r_busy;
    assign bus.tmo_err   = r_tmo_err;
    assign bus.dbg_state = r_state;

endmodule
